// File: rtl/linebuf_pkg.sv
// Shared state encoding and pixel-format constants for the scanline buffer sequencer.
package linebuf_pkg;

    localparam int LINE_PIXELS = 256;
    localparam int IDX_W       = 8;

    localparam int         PIX_PRI_BIT  = 7;
    localparam int         PIX_SPR_BIT  = 5;
    localparam logic [4:0] SPR_PAL_BASE = 5'h10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BG      = 3'd1,
        SPR_REQ = 3'd2,
        SPR_RMW = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Background pixels keep only priority and palette index; bits 6:5 are cleared.
    function automatic logic [7:0] bg_pixel(input logic [7:0] raw);
        return {raw[7], 2'b00, raw[4:0]};
    endfunction

endpackage

// File: rtl/linebuf_spr_merge.sv
// Combinational sprite-over-pixel merge: first sprite wins, priority background
// hides the sprite but still marks the pixel occupied.
module linebuf_spr_merge
    import linebuf_pkg::*;
(
    input  logic [7:0] old_pix_i,
    input  logic [3:0] color_i,
    output logic [7:0] new_pix_o,
    output logic       collision_o
);

    // Resolve the stored pixel against one opaque sprite colour.
    always_comb begin
        new_pix_o   = old_pix_i;
        collision_o = 1'b0;
        if (old_pix_i[PIX_SPR_BIT]) begin
            collision_o = 1'b1;
        end else if (old_pix_i[PIX_PRI_BIT] && (old_pix_i[3:0] != 4'h0)) begin
            new_pix_o[PIX_SPR_BIT] = 1'b1;
        end else begin
            new_pix_o = {2'b00, 1'b1, SPR_PAL_BASE | {1'b0, color_i}};
        end
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Scanline buffer sequencer: swaps buffer halves on line start, fills the render
// half with background pixels, then merges sprites by read-modify-write on port 1.
module linebuf_ctrl
    import linebuf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_start,
    output logic             linesel,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             bg_valid,
    output logic             bg_ready,
    input  logic [7:0]       bg_data,
    input  logic             spr_valid,
    output logic             spr_ready,
    input  logic [IDX_W-1:0] spr_x,
    input  logic [3:0]       spr_color,
    input  logic             spr_last,
    output logic             spr_collision,
    output logic [IDX_W-1:0] lb_idx,
    output logic [7:0]       lb_wrdata,
    output logic             lb_wren,
    input  logic [7:0]       lb_rddata
);

    localparam logic [IDX_W-1:0] BG_LAST = IDX_W'(LINE_PIXELS - 1);

    state_e           state_q, state_d;
    logic             linesel_q, linesel_d;
    logic [IDX_W-1:0] bg_cnt_q, bg_cnt_d;
    logic [IDX_W-1:0] spr_x_q, spr_x_d;
    logic [3:0]       spr_color_q, spr_color_d;
    logic             spr_last_q, spr_last_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             coll_q, coll_d;
    logic [7:0]       merge_pix_s;
    logic             merge_coll_s;

    linebuf_spr_merge u_merge (
        .old_pix_i   (lb_rddata),
        .color_i     (spr_color_q),
        .new_pix_o   (merge_pix_s),
        .collision_o (merge_coll_s)
    );

    assign linesel       = linesel_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overrun       = overrun_q;
    assign spr_collision = coll_q;

    // Next-state and line buffer port 1 drive; line_start overrides everything.
    always_comb begin
        state_d     = state_q;
        linesel_d   = linesel_q;
        bg_cnt_d    = bg_cnt_q;
        spr_x_d     = spr_x_q;
        spr_color_d = spr_color_q;
        spr_last_d  = spr_last_q;
        overrun_d   = 1'b0;
        coll_d      = 1'b0;
        bg_ready    = 1'b0;
        spr_ready   = 1'b0;
        lb_idx      = '0;
        lb_wrdata   = 8'h00;
        lb_wren     = 1'b0;
        if (line_start) begin
            state_d   = BG;
            linesel_d = ~linesel_q;
            bg_cnt_d  = '0;
            overrun_d = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                BG: begin
                    bg_ready = 1'b1;
                    lb_idx   = bg_cnt_q;
                    if (bg_valid) begin
                        lb_wren   = 1'b1;
                        lb_wrdata = bg_pixel(bg_data);
                        bg_cnt_d  = bg_cnt_q + 1'b1;
                        state_d   = (bg_cnt_q == BG_LAST) ? SPR_REQ : BG;
                    end else begin
                        state_d = BG;
                    end
                end
                SPR_REQ: begin
                    spr_ready = 1'b1;
                    lb_idx    = spr_x;
                    if (!spr_valid) begin
                        state_d = SPR_REQ;
                    end else if (spr_color == 4'h0) begin
                        state_d = spr_last ? DONE : SPR_REQ;
                    end else begin
                        spr_x_d     = spr_x;
                        spr_color_d = spr_color;
                        spr_last_d  = spr_last;
                        state_d     = SPR_RMW;
                    end
                end
                SPR_RMW: begin
                    // Read data addressed in SPR_REQ arrives now; write back in place.
                    lb_idx    = spr_x_q;
                    lb_wren   = 1'b1;
                    lb_wrdata = merge_pix_s;
                    coll_d    = merge_coll_s;
                    state_d   = spr_last_q ? DONE : SPR_REQ;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        done_d = (state_d == DONE);
    end

    // State, capture and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            linesel_q   <= 1'b0;
            bg_cnt_q    <= '0;
            spr_x_q     <= '0;
            spr_color_q <= 4'h0;
            spr_last_q  <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            linesel_q   <= linesel_d;
            bg_cnt_q    <= bg_cnt_d;
            spr_x_q     <= spr_x_d;
            spr_color_q <= spr_color_d;
            spr_last_q  <= spr_last_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            coll_q      <= coll_d;
        end
    end

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Scoreboard bench for linebuf_ctrl with a behavioural dual-half line buffer on port 1.
module tb_linebuf_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_start = 1'b0;
    logic       linesel, busy, done, overrun;
    logic       bg_valid = 1'b0;
    logic       bg_ready;
    logic [7:0] bg_data = 8'h00;
    logic       spr_valid = 1'b0;
    logic       spr_ready;
    logic [7:0] spr_x = 8'h00;
    logic [3:0] spr_color = 4'h0;
    logic       spr_last = 1'b0;
    logic       spr_collision;
    logic [7:0] lb_idx, lb_wrdata, lb_rddata;
    logic       lb_wren;

    logic [7:0]  ram [0:511];
    logic [7:0]  ref_pix [0:511];
    logic [16:0] exp_q [$];
    logic        ls_exp = 1'b0;
    logic [7:0]  bg_idx = 8'h00;
    int n_cmp = 0, n_err = 0;
    int exp_coll = 0, exp_done = 0;
    int coll_seen = 0, done_seen = 0, ovr_seen = 0;

    always #5 clk = ~clk;

    linebuf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start),
        .linesel(linesel), .busy(busy), .done(done), .overrun(overrun),
        .bg_valid(bg_valid), .bg_ready(bg_ready), .bg_data(bg_data),
        .spr_valid(spr_valid), .spr_ready(spr_ready), .spr_x(spr_x),
        .spr_color(spr_color), .spr_last(spr_last), .spr_collision(spr_collision),
        .lb_idx(lb_idx), .lb_wrdata(lb_wrdata), .lb_wren(lb_wren), .lb_rddata(lb_rddata)
    );

    // Line buffer port 1: registered read, write addressed by the render half.
    always @(posedge clk) begin
        lb_rddata <= ram[{linesel, lb_idx}];
        if (lb_wren) ram[{linesel, lb_idx}] <= lb_wrdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    // Write monitor and pulse counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lb_wren) begin
                if (exp_q.size() == 0) check("wr_unexpected", 32'({linesel, lb_idx, lb_wrdata}), 32'h1FFFF);
                else check("wr", 32'({linesel, lb_idx, lb_wrdata}), 32'(exp_q.pop_front()));
            end
            if (spr_collision) coll_seen++;
            if (done) done_seen++;
            if (overrun) ovr_seen++;
        end
    end

    function automatic logic [7:0] bg_pat(input logic [7:0] idx, input logic plain);
        if (plain) return 8'h05;
        else if (idx == 8'd10) return 8'h02;
        else if (idx == 8'd20) return 8'h85;
        else return 8'h65;
    endfunction

    // {collision, new pixel} for one opaque sprite over a stored pixel.
    function automatic logic [8:0] merge_model(input logic [7:0] old, input logic [3:0] c);
        if ((old & 8'h20) != 8'h00) return {1'b1, old};
        if ((old & 8'h80) != 8'h00 && (old & 8'h0F) != 8'h00) return {1'b0, old | 8'h20};
        return {1'b0, 8'h30 | {4'h0, c}};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        ls_exp = ~ls_exp;
        bg_idx = 8'h00;
        step();
        line_start = 1'b0;
    endtask

    task automatic send_bg(input int n, input logic plain);
        int got = 0;
        int cyc = 0;
        logic [7:0] d;
        bg_valid = 1'b1;
        while (got < n && cyc < n + 20) begin
            d = bg_pat(bg_idx, plain);
            bg_data = d;
            #1;
            if (bg_ready) begin
                exp_q.push_back({ls_exp, bg_idx, d & 8'h9F});
                ref_pix[{ls_exp, bg_idx}] = d & 8'h9F;
                bg_idx++;
                got++;
            end
            step();
            cyc++;
        end
        bg_valid = 1'b0;
        check("bg_beats", 32'(got), 32'(n));
        check("bg_cycles", 32'(cyc), 32'(n));
    endtask

    task automatic send_spr(input logic [7:0] x, input logic [3:0] c, input logic l);
        logic [8:0] m;
        int cyc = 0;
        logic acc = 1'b0;
        spr_valid = 1'b1; spr_x = x; spr_color = c; spr_last = l;
        while (!acc && cyc < 10) begin
            #1;
            if (spr_ready) begin
                acc = 1'b1;
                if (c != 4'h0) begin
                    m = merge_model(ref_pix[{ls_exp, x}], c);
                    exp_q.push_back({ls_exp, x, m[7:0]});
                    ref_pix[{ls_exp, x}] = m[7:0];
                    exp_coll += int'(m[8]);
                end
                if (l) exp_done++;
            end
            step();
            cyc++;
        end
        spr_valid = 1'b0; spr_last = 1'b0;
        check("spr_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_pix[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_linesel", 32'(linesel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({done, overrun, bg_ready, spr_ready, spr_collision, lb_wren}), 32'd0);
        check("rst_lb", 32'({lb_idx, lb_wrdata}), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of the background fill.
        pulse_line_start();
        send_bg(37, 1'b1);
        check("bg_ready_37", 32'(bg_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 32'({busy, linesel, bg_ready, lb_wren, done, overrun}), 32'd0);
        check("mid_rst_idx", 32'(lb_idx), 32'd0);
        ls_exp = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 32'({busy, linesel}), 32'd0);

        // Plain line: 256 background beats then a single transparent last beat.
        pulse_line_start();
        check("l1_linesel", 32'(linesel), 32'd1);
        check("l1_busy", 32'(busy), 32'd1);
        send_bg(256, 1'b0 | 1'b1);
        check("l1_spr_req_257", 32'(spr_ready), 32'd1);
        send_spr(8'd100, 4'h0, 1'b1);
        check("l1_done", 32'({done, busy}), 32'b11);
        step();
        check("l1_idle", 32'({done, busy}), 32'd0);

        // Sprite merge line.
        pulse_line_start();
        send_bg(256, 1'b0);
        send_spr(8'd10, 4'h3, 1'b0);
        check("rmw_timing", 32'({lb_wren, lb_idx, lb_wrdata}), 32'h10A33);
        send_spr(8'd10, 4'h7, 1'b0);
        check("coll_keep", 32'({lb_wren, lb_wrdata}), 32'h133);
        send_spr(8'd20, 4'h4, 1'b0);
        send_spr(8'd20, 4'h1, 1'b0);
        send_spr(8'd30, 4'h0, 1'b0);
        send_spr(8'd40, 4'h5, 1'b1);
        step();
        check("l2_done", 32'(done), 32'd1);
        step();
        check("px10", 32'(ram[{ls_exp, 8'd10}]), 32'h33);
        check("px20", 32'(ram[{ls_exp, 8'd20}]), 32'hA5);
        check("px30", 32'(ram[{ls_exp, 8'd30}]), 32'h05);
        check("px40", 32'(ram[{ls_exp, 8'd40}]), 32'h35);

        // Overrun: line_start arrives at bg_cnt=100 with valid held high.
        pulse_line_start();
        send_bg(100, 1'b1);
        line_start = 1'b1; bg_valid = 1'b1; bg_data = 8'h05;
        #1;
        check("ovr_no_ready", 32'({bg_ready, lb_wren}), 32'd0);
        ls_exp = ~ls_exp;
        bg_idx = 8'h00;
        step();
        line_start = 1'b0; bg_valid = 1'b0;
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_linesel", 32'(linesel), 32'(ls_exp));
        step();
        check("ovr_single", 32'(overrun), 32'd0);
        send_bg(256, 1'b1);
        send_spr(8'd0, 4'h0, 1'b1);
        step();
        step();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("coll_count", 32'(coll_seen), 32'(exp_coll));
        check("coll_two", 32'(coll_seen), 32'd2);
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("ovr_count", 32'(ovr_seen), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
